// File: rtl/btn_event_pkg.sv
// Shared definitions for the button event FSM: state encodings and counter sizing.
// WAIT is only reachable when BTN_DOUBLE_CLICK_EN is defined.
package btn_event_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRESS = 2'd1;
    localparam logic [1:0] ST_LONG  = 2'd2;
    localparam logic [1:0] ST_WAIT  = 2'd3;

    // Enough bits to hold the largest threshold; the counter saturates there.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/edge_detect.sv
// Registers a level one clock and flags its rising and falling edges.
// Synchronous active-high reset clears the history to 0.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic level_i,
    output logic rise_o,
    output logic fall_o
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = level_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    always_comb begin
        rise_o = level_i & ~prev_q;
        fall_o = ~level_i & prev_q;
    end

endmodule

// File: rtl/button_event_fsm.sv
// Turns a debounced button level into press/release/long/repeat pulses and a held level.
// Define BTN_DOUBLE_CLICK_EN to add the WAIT state and the dclick_o pulse.
module button_event_fsm
    import btn_event_pkg::*;
#(
    parameter int unsigned LONG_CYCLES   = 1000,
    parameter int unsigned REPEAT_CYCLES = 200,
    parameter int unsigned DCLICK_CYCLES = 300
) (
    input  logic clk,
    input  logic rst,
    input  logic clean_in,
    output logic press_o,
    output logic release_o,
    output logic long_o,
    output logic repeat_o,
    output logic held_o,
    output logic dclick_o
);

    localparam int unsigned CW = cnt_width(LONG_CYCLES, REPEAT_CYCLES, DCLICK_CYCLES);
    localparam logic [CW-1:0] CNT_MAX   = '1;
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);

    logic rise;
    logic fall;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    logic press_q, press_d;
    logic release_q, release_d;
    logic long_q, long_d;
    logic repeat_q, repeat_d;
    logic held_q, held_d;

    edge_detect u_edge_detect (
        .clk     (clk),
        .rst     (rst),
        .level_i (clean_in),
        .rise_o  (rise),
        .fall_o  (fall)
    );

`ifdef BTN_DOUBLE_CLICK_EN
    localparam logic [CW-1:0] DCLICK_LAST = CW'(DCLICK_CYCLES - 1);

    // Marks a press that was itself a double click, so its release does not re-arm WAIT.
    logic dc_press_q, dc_press_d;
    logic dclick_q, dclick_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            dc_press_q <= 1'b0;
            dclick_q   <= 1'b0;
        end else begin
            dc_press_q <= dc_press_d;
            dclick_q   <= dclick_d;
        end
    end

    assign dclick_o = dclick_q;
`else
    assign dclick_o = 1'b0;
`endif

    always_comb begin
        cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
`ifdef BTN_DOUBLE_CLICK_EN
        dc_press_d = dc_press_q;
        dclick_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_PRESS;
                    cnt_d   = '0;
                    press_d = 1'b1;
`ifdef BTN_DOUBLE_CLICK_EN
                    dc_press_d = 1'b0;
`endif
                end
            end
            ST_PRESS: begin
                // A fall beats a threshold hit in the same cycle.
                if (fall) begin
                    release_d = 1'b1;
                    cnt_d     = '0;
`ifdef BTN_DOUBLE_CLICK_EN
                    state_d = dc_press_q ? ST_IDLE : ST_WAIT;
`else
                    state_d = ST_IDLE;
`endif
                end else if (cnt_q == LONG_LAST) begin
                    state_d = ST_LONG;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_LONG: begin
                if (fall) begin
                    state_d   = ST_IDLE;
                    release_d = 1'b1;
                end else if (cnt_q == REP_LAST) begin
                    cnt_d    = '0;
                    repeat_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
`ifdef BTN_DOUBLE_CLICK_EN
            ST_WAIT: begin
                if (rise) begin
                    state_d    = ST_PRESS;
                    cnt_d      = '0;
                    press_d    = 1'b1;
                    dclick_d   = 1'b1;
                    dc_press_d = 1'b1;
                end else if (cnt_q == DCLICK_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        held_d = (state_d == ST_PRESS) || (state_d == ST_LONG);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            held_q    <= held_d;
        end
    end

    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;
    assign repeat_o  = repeat_q;
    assign held_o    = held_q;

endmodule

// File: tb/tb_button_event_fsm.sv
// Directed bench for button_event_fsm (LONG=16, REPEAT=4, DCLICK=8).
// Double-click expectations follow BTN_DOUBLE_CLICK_EN.
module tb_button_event_fsm;

    logic clk;
    logic rst;
    logic clean_in;
    logic press_o, release_o, long_o, repeat_o, held_o, dclick_o;

`ifdef BTN_DOUBLE_CLICK_EN
    localparam int DC_ON = 1;
`else
    localparam int DC_ON = 0;
`endif

    button_event_fsm #(
        .LONG_CYCLES   (16),
        .REPEAT_CYCLES (4),
        .DCLICK_CYCLES (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clean_in  (clean_in),
        .press_o   (press_o),
        .release_o (release_o),
        .long_o    (long_o),
        .repeat_o  (repeat_o),
        .held_o    (held_o),
        .dclick_o  (dclick_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;
    int t;
    int n_press, n_rel, n_long, n_rep, n_held, n_dclick;
    int press_t, rel_t, long_t, dclick_t;
    int rep_ts[8];
    int viol;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        n_press = 0; n_rel = 0; n_long = 0; n_rep = 0; n_held = 0; n_dclick = 0;
        press_t = -1; rel_t = -1; long_t = -1; dclick_t = -1;
        for (int i = 0; i < 8; i++) rep_ts[i] = -1;
    endtask

    // Drive one input value across one rising edge and log the resulting outputs.
    task automatic cyc(input logic v);
        clean_in = v;
        @(posedge clk);
        #1;
        t++;
        if (press_o) begin n_press++; press_t = t; end
        if (release_o) begin n_rel++; rel_t = t; end
        if (long_o) begin n_long++; long_t = t; end
        if (repeat_o) begin
            if (n_rep < 8) rep_ts[n_rep] = t;
            n_rep++;
        end
        if (held_o) n_held++;
        if (dclick_o) begin n_dclick++; dclick_t = t; end
        if ($countones({press_o, release_o, long_o, repeat_o}) > 1) viol++;
        if (dclick_o && !press_o) viol++;
    endtask

    task automatic hold(input logic v, input int n);
        for (int i = 0; i < n; i++) cyc(v);
    endtask

    int first_press;

    initial begin
        n_tests = 0; n_fail = 0; t = 0; viol = 0;
        rst = 1'b1;
        clean_in = 1'b0;
        clear_stats();
        hold(1'b0, 3);
        check_eq("reset_outputs",
                 int'({press_o, release_o, long_o, repeat_o, held_o, dclick_o}), 0);
        rst = 1'b0;
        hold(1'b0, 3);

        // 1. short press
        clear_stats();
        hold(1'b1, 5);
        hold(1'b0, 12);
        check_eq("short_press_cnt", n_press, 1);
        check_eq("short_rel_cnt", n_rel, 1);
        check_eq("short_rel_delay", rel_t - press_t, 5);
        check_eq("short_held_cycles", n_held, 5);
        check_eq("short_no_long", n_long, 0);

        // 2. long hold with repeats
        clear_stats();
        hold(1'b1, 30);
        hold(1'b0, 12);
        check_eq("long_cnt", n_long, 1);
        check_eq("long_delay", long_t - press_t, 16);
        check_eq("repeat_cnt", n_rep, 3);
        check_eq("repeat1_delay", rep_ts[0] - long_t, 4);
        check_eq("repeat2_delay", rep_ts[1] - long_t, 8);
        check_eq("long_rel_delay", rel_t - press_t, 30);
        check_eq("long_held_cycles", n_held, 30);

        // 3. fall exactly at the long threshold: release wins
        clear_stats();
        hold(1'b1, 16);
        hold(1'b0, 12);
        check_eq("bnd_long_none", n_long, 0);
        check_eq("bnd_long_rel", rel_t - press_t, 16);
        // one clock later the long pulse does fire
        clear_stats();
        hold(1'b1, 17);
        hold(1'b0, 12);
        check_eq("bnd_long_fires", n_long, 1);
        check_eq("bnd_long_rel_after", rel_t - press_t, 17);
        // fall exactly at the first repeat threshold
        clear_stats();
        hold(1'b1, 20);
        hold(1'b0, 12);
        check_eq("bnd_rep_none", n_rep, 0);
        check_eq("bnd_rep_rel", rel_t - press_t, 20);

        // 4. reset in the middle of LONG
        clear_stats();
        hold(1'b1, 20);
        check_eq("pre_reset_long", n_long, 1);
        clear_stats();
        rst = 1'b1;
        cyc(1'b1);
        check_eq("mid_reset_outputs",
                 int'({press_o, release_o, long_o, repeat_o, held_o, dclick_o}), 0);
        first_press = t + 1;
        rst = 1'b0;
        hold(1'b1, 3);
        check_eq("mid_reset_no_rel", n_rel, 0);
        check_eq("post_reset_press", press_t, first_press);
        check_eq("post_reset_press_cnt", n_press, 1);
        hold(1'b0, 12);

        // 5. double click with a 5-clock gap
        clear_stats();
        hold(1'b1, 3);
        hold(1'b0, 5);
        hold(1'b1, 3);
        hold(1'b0, 12);
        check_eq("dc_press_cnt", n_press, 2);
        check_eq("dc_dclick_cnt", n_dclick, DC_ON);
        if (DC_ON != 0) check_eq("dc_with_press", dclick_t, press_t);
        // triple click: dclick then a plain single
        clear_stats();
        hold(1'b1, 3);
        hold(1'b0, 5);
        hold(1'b1, 3);
        hold(1'b0, 5);
        hold(1'b1, 3);
        hold(1'b0, 12);
        check_eq("triple_press_cnt", n_press, 3);
        check_eq("triple_dclick_cnt", n_dclick, DC_ON);
        // window expired with a 9-clock gap
        clear_stats();
        hold(1'b1, 3);
        hold(1'b0, 9);
        hold(1'b1, 3);
        hold(1'b0, 12);
        check_eq("gap9_press_cnt", n_press, 2);
        check_eq("gap9_dclick_cnt", n_dclick, 0);

        // 6. long release never arms the window
        clear_stats();
        hold(1'b1, 20);
        hold(1'b0, 2);
        hold(1'b1, 3);
        hold(1'b0, 12);
        check_eq("long_then_quick_long", n_long, 1);
        check_eq("long_then_quick_press", n_press, 2);
        check_eq("long_then_quick_dclick", n_dclick, 0);

        check_eq("one_event_per_cycle", viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
